prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that sits directly upstream of the `cpu` top. It accepts a framed byte stream, assembles little-endian 32-bit instruction words and 64-bit data words, and writes them into instruction and data memory through the CPU's external memory ports. When the image is complete, it asserts the CPU's `enable`. It holds the CPU disabled during loading and reports malformed headers.

## Interface
- `IMEM_WORDS`, 512, capacity of instruction memory in 32-bit words.
- `DMEM_WORDS`, 1024, capacity of data memory in 64-bit words.
- `IMEM_BASE`, 0, byte address of the first instruction word.
- `DMEM_BASE`, 0, byte address of the first data word.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `arst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin loading; honoured only in IDLE.
- `in_valid` input 1: stream byte valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte.
- `addr_ext` output 64: instruction memory byte address.
- `wen_ext` output 1: instruction memory write strobe.
- `wdata_ext` output 32: instruction word.
- `ren_ext` output 1: constant 0.
- `addr_ext_2` output 64: data memory byte address.
- `wen_ext_2` output 1: data memory write strobe.
- `wdata_ext_2` output 64: data word.
- `ren_ext_2` output 1: constant 0.
- `cpu_enable` output 1: drives CPU `enable`.
- `busy` output 1: high in HDR, IMEM and DMEM.
- `error` output 1: high in ERR.

## Operation
- **Frame layout:** 2-byte `icount` (LE), then 2-byte `dcount` (LE), then `icount` × 4 bytes, then `dcount` × 8 bytes. All multibyte values are little-endian; the first byte goes to bits [7:0].
- **Handshake:** a byte transfers on a rising edge with `in_valid & in_ready`. `in_ready` is 1 in HDR, IMEM and DMEM, and 0 otherwise. `in_valid` low stalls the loader indefinitely with no timeout.
- **States:** IDLE, HDR, IMEM, DMEM, RUN, ERR.
- **IDLE → HDR:** on `start`.
- **HDR:** counts 4 bytes. On the 4th byte the next state depends on the counts:
  - ERR if `icount > IMEM_WORDS` or `dcount > DMEM_WORDS`.
  - Otherwise IMEM if `icount ≠ 0`.
  - Otherwise DMEM if `dcount ≠ 0`.
  - Otherwise RUN.
- **IMEM:** 2-bit byte index, 16-bit word counter.
  - The 4th byte of a word registers `wdata_ext` and `addr_ext = IMEM_BASE + 4·k`, and pulses `wen_ext`.
  - After word `icount−1`, the next state is DMEM, or RUN if `dcount = 0`.
- **DMEM:** same scheme with a 3-bit byte index.
  - The 8th byte registers `wdata_ext_2` and `addr_ext_2 = DMEM_BASE + 8·k`, and pulses `wen_ext_2`.
  - After word `dcount−1`, the next state is RUN.
- **RUN:** `cpu_enable = 1`; terminal until reset. `start` is ignored.
- **ERR:** terminal until reset. No memory write is ever issued for a rejected frame. `start` is ignored.
- **Address arithmetic:** 64-bit unsigned. Word counters are 16-bit.
- **Reset values:** every output is 0, and the state is IDLE.

## Timing
- `wen_ext` and `wen_ext_2` are registered one-cycle pulses. They are high in the cycle after the edge that accepts the final byte of a word, and address and data are stable during that cycle.
- Outside a strobe, `addr_ext`, `addr_ext_2`, `wdata_ext` and `wdata_ext_2` hold their last values.
- `in_ready` stays high during a write-strobe cycle, giving a sustained throughput of 1 byte/cycle with no bubbles between words.
- The final write strobe and the state change to RUN occur on the same edge. `cpu_enable` rises on the following edge, so the CPU never runs in the same cycle as the last write.
- With `icount = dcount = 0`, `cpu_enable` rises 2 cycles after the 4th header byte is accepted.
- `error` rises 1 cycle after the 4th header byte of a bad header. `in_ready` drops on that same edge.
- `start` asserted while a byte handshake is in progress has no effect outside IDLE.
- `arst` mid-load: all outputs clear asynchronously, including any strobe in flight. Partially assembled words are discarded; memory contents already written are left untouched.

## Test plan
- **Basic load:** `start`; header 02 00 01 00; bytes 13 05 10 00 93 05 20 00; then 8 bytes 11..18 with `in_valid` held high.
  - `wen_ext` pulses with addr 0 / data 0x00100513, then addr 4 / data 0x00200593.
  - `wen_ext_2` pulses once with addr 0 / data 0x1817161514131211.
  - `cpu_enable` rises one cycle after that pulse.
- **Stall:** the same frame with `in_valid` toggling on alternate cycles. Required: identical writes, in the same order, at half rate; no duplicate strobes.
- **Empty image:** header 00 00 00 00. Required: no strobes; `cpu_enable` rises 2 cycles after the last header byte; `busy` falls.
- **Oversize:** header 01 02 00 00 (`icount = 513`). Required: `error = 1`, `in_ready = 0`, no strobes; a later `start` is ignored.
- **Reset mid-load:** `arst` after byte 2 of the first instruction word.
  - Outputs are immediately 0.
  - After release, a fresh `start` plus the basic-load frame reproduces the basic-load results exactly.
- **Back-to-back bytes across the section boundary** (`icount = 1`, `dcount = 1`, continuous valid): the `wen_ext` pulse and the first DMEM byte acceptance occur in the same cycle; the data word is correct.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a framed LE image and writes instruction/data
// words through the CPU's external memory ports, then releases the CPU.
module prog_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [63:0] IMEM_BASE  = '0,
  parameter logic [63:0] DMEM_BASE  = '0
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic        ren_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        ren_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HDR, IMEM, DMEM, RUN, ERR} state_e;

  localparam logic [16:0] ILIM = 17'(IMEM_WORDS);
  localparam logic [16:0] DLIM = 17'(DMEM_WORDS);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] icnt_q, icnt_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic [63:0] asm_q, asm_d;
  logic [63:0] iaddr_q, iaddr_d;
  logic [31:0] idata_q, idata_d;
  logic        iwen_q, iwen_d;
  logic [63:0] daddr_q, daddr_d;
  logic [63:0] ddata_q, ddata_d;
  logic        dwen_q, dwen_d;
  logic        en_q;
  logic        accept;

  assign busy     = (state_q == HDR) || (state_q == IMEM) || (state_q == DMEM);
  assign in_ready = busy;
  assign error    = (state_q == ERR);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    asm_d   = asm_q;
    iaddr_d = iaddr_q;
    idata_d = idata_q;
    iwen_d  = 1'b0;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    dwen_d  = 1'b0;

    // The byte lands in the assembly buffer before the word/header is decoded,
    // so the completing byte is visible through asm_d in the same cycle.
    if (accept) asm_d[{idx_q, 3'b000} +: 8] = in_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          idx_d   = '0;
          wcnt_d  = '0;
        end
      end
      HDR: begin
        if (accept) begin
          if (idx_q == 3'd3) begin
            icnt_d = asm_d[15:0];
            dcnt_d = asm_d[31:16];
            idx_d  = '0;
            wcnt_d = '0;
            if (({1'b0, asm_d[15:0]} > ILIM) || ({1'b0, asm_d[31:16]} > DLIM))
              state_d = ERR;
            else if (asm_d[15:0] != '0)
              state_d = IMEM;
            else if (asm_d[31:16] != '0)
              state_d = DMEM;
            else
              state_d = RUN;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      IMEM: begin
        if (accept) begin
          if (idx_q == 3'd3) begin
            idata_d = asm_d[31:0];
            iaddr_d = IMEM_BASE + {46'b0, wcnt_q, 2'b00};
            iwen_d  = 1'b1;
            idx_d   = '0;
            if (wcnt_q == icnt_q - 16'd1) begin
              wcnt_d  = '0;
              state_d = (dcnt_q != '0) ? DMEM : RUN;
            end else begin
              wcnt_d = wcnt_q + 16'd1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DMEM: begin
        if (accept) begin
          if (idx_q == 3'd7) begin
            ddata_d = asm_d;
            daddr_d = DMEM_BASE + {45'b0, wcnt_q, 3'b000};
            dwen_d  = 1'b1;
            idx_d   = '0;
            if (wcnt_q == dcnt_q - 16'd1) begin
              wcnt_d  = '0;
              state_d = RUN;
            end else begin
              wcnt_d = wcnt_q + 16'd1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      asm_q   <= '0;
      iaddr_q <= '0;
      idata_q <= '0;
      iwen_q  <= 1'b0;
      daddr_q <= '0;
      ddata_q <= '0;
      dwen_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      asm_q   <= asm_d;
      iaddr_q <= iaddr_d;
      idata_q <= idata_d;
      iwen_q  <= iwen_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      dwen_q  <= dwen_d;
      en_q    <= (state_q == RUN);
    end
  end

  assign addr_ext    = iaddr_q;
  assign wen_ext     = iwen_q;
  assign wdata_ext   = idata_q;
  assign ren_ext     = 1'b0;
  assign addr_ext_2  = daddr_q;
  assign wen_ext_2   = dwen_q;
  assign wdata_ext_2 = ddata_q;
  assign ren_ext_2   = 1'b0;
  assign cpu_enable  = en_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames, write-strobe scoreboard, and hand-written
// reset/boundary sequences.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, error;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;
  logic        any_out;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .arst(arst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .ren_ext(ren_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .wdata_ext_2(wdata_ext_2), .ren_ext_2(ren_ext_2), .cpu_enable(cpu_enable),
    .busy(busy), .error(error)
  );

  assign any_out = |{in_ready, addr_ext, wen_ext, wdata_ext, ren_ext, addr_ext_2, wen_ext_2,
                     wdata_ext_2, ren_ext_2, cpu_enable, busy, error};

  typedef struct {
    logic [15:0] ic;
    logic [15:0] dc;
    bit          stall;
    bit          exp_err;
    logic [31:0] iw0;
    logic [31:0] iw1;
    logic [63:0] dw0;
  } frame_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;

  localparam int unsigned NF = 10;
  frame_t tbl [NF];
  wr_t    iq[$], dq[$];
  wr_t    ie, de;
  int     tests = 0;
  int     fails = 0;
  bit     overlap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] iword(input frame_t f, input int unsigned k);
    if (k == 0) return f.iw0;
    if (k == 1) return f.iw1;
    return 32'hC0DE0000 ^ (k * 32'h00010003);
  endfunction

  function automatic logic [63:0] dword(input frame_t f, input int unsigned k);
    if (k == 0) return f.dw0;
    return {k * 32'd7, 32'hFEED0000 + k};
  endfunction

  // Scoreboard: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!arst) begin
      if (wen_ext) begin
        overlap = in_valid && in_ready;
        if (iq.size() == 0) check("imem_unexpected_strobe", 64'(wen_ext), 64'd0);
        else begin
          ie = iq.pop_front();
          check("imem_addr", addr_ext, ie.a);
          check("imem_data", 64'(wdata_ext), ie.d);
        end
      end
      if (wen_ext_2) begin
        if (dq.size() == 0) check("dmem_unexpected_strobe", 64'(wen_ext_2), 64'd0);
        else begin
          de = dq.pop_front();
          check("dmem_addr", addr_ext_2, de.a);
          check("dmem_data", wdata_ext_2, de.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    iq.delete(); dq.delete();
    arst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int unsigned n;
    n = 0;
    if (stall) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 16) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
  endtask

  task automatic send_frame(input int unsigned f);
    frame_t      fr;
    logic [7:0]  h [4];
    logic [31:0] w;
    logic [63:0] dw;
    fr = tbl[f];
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("ready_after_start", 64'(in_ready), 64'd1);
    h[0] = fr.ic[7:0]; h[1] = fr.ic[15:8]; h[2] = fr.dc[7:0]; h[3] = fr.dc[15:8];
    for (int i = 0; i < 4; i++) send_byte(h[i], fr.stall);
    if (fr.exp_err) begin
      in_valid = 1'b0;
      check("err_error", 64'(error), 64'd1);
      check("err_ready", 64'(in_ready), 64'd0);
      check("err_busy", 64'(busy), 64'd0);
      start = 1'b1; tick(); start = 1'b0; tick(); tick();
      check("err_start_ignored_error", 64'(error), 64'd1);
      check("err_start_ignored_busy", 64'(busy), 64'd0);
      check("err_cpu_enable", 64'(cpu_enable), 64'd0);
      return;
    end
    start = fr.stall;
    for (int unsigned k = 0; k < fr.ic; k++) begin
      w = iword(fr, k);
      iq.push_back('{a: 64'(k) * 64'd4, d: 64'(w)});
      for (int unsigned b = 0; b < 4; b++) send_byte(w[8*b +: 8], fr.stall);
    end
    for (int unsigned k = 0; k < fr.dc; k++) begin
      dw = dword(fr, k);
      dq.push_back('{a: 64'(k) * 64'd8, d: dw});
      for (int unsigned b = 0; b < 8; b++) send_byte(dw[8*b +: 8], fr.stall);
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (fr.dc != 0) check("last_strobe_dmem", 64'(wen_ext_2), 64'd1);
    else if (fr.ic != 0) check("last_strobe_imem", 64'(wen_ext), 64'd1);
    check("cpu_enable_not_with_write", 64'(cpu_enable), 64'd0);
    tick();
    check("cpu_enable_rise", 64'(cpu_enable), 64'd1);
    check("busy_fall", 64'(busy), 64'd0);
    check("no_error", 64'(error), 64'd0);
    tick();
    check("imem_writes_missing", 64'(iq.size()), 64'd0);
    check("dmem_writes_missing", 64'(dq.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'd2, 16'd1, 1'b0, 1'b0, 32'h00100513, 32'h00200593, 64'h1817161514131211};
    tbl[1] = '{16'd2, 16'd1, 1'b1, 1'b0, 32'h00100513, 32'h00200593, 64'h1817161514131211};
    tbl[2] = '{16'd0, 16'd0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0};
    tbl[3] = '{16'd513, 16'd0, 1'b0, 1'b1, 32'h0, 32'h0, 64'h0};
    tbl[4] = '{16'd0, 16'd1025, 1'b0, 1'b1, 32'h0, 32'h0, 64'h0};
    tbl[5] = '{16'd1, 16'd1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 64'h0123456789ABCDEF};
    tbl[6] = '{16'd0, 16'd3, 1'b0, 1'b0, 32'h0, 32'h0, 64'hA1B2C3D4E5F60718};
    tbl[7] = '{16'd3, 16'd2, 1'b1, 1'b0, 32'h11223344, 32'h55667788, 64'h99AABBCCDDEEFF00};
    tbl[8] = '{16'd512, 16'd0, 1'b0, 1'b0, 32'h0000006F, 32'hFFFFFFFF, 64'h0};
    tbl[9] = '{16'd0, 16'd1024, 1'b0, 1'b0, 32'h0, 32'h0, 64'h8000000000000001};

    arst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #3;
    check("reset_outputs_zero", 64'(any_out), 64'd0);

    for (int unsigned f = 0; f < NF; f++) begin
      do_reset();
      overlap = 1'b0;
      send_frame(f);
      if (f == 5) check("boundary_strobe_with_dmem_accept", 64'(overlap), 64'd1);
    end

    // Reset after the second byte of the first instruction word.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0); send_byte(8'h05, 1'b0);
    in_valid = 1'b0;
    check("midload_busy", 64'(busy), 64'd1);
    #1 arst = 1'b1;
    #1 check("midload_reset_outputs_zero", 64'(any_out), 64'd0);
    do_reset();
    send_frame(0);

    // Reset while a write strobe is in flight.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
    in_valid = 1'b0;
    check("inflight_wen", 64'(wen_ext), 64'd1);
    check("inflight_data", 64'(wdata_ext), 64'hDEADBEEF);
    arst = 1'b1;
    #1 check("inflight_reset_outputs_zero", 64'(any_out), 64'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
